// File: rtl/counter_updown_param.sv
// rtl/counter_updown_param.sv - parametrised up/down counter with modulus, wrap/saturate and load checking
module counter_updown_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic at_max, at_zero;
    assign at_max  = (count_q == MAX_C);
    assign at_zero = (count_q == ZERO_C);

    // Pulses default low every cycle; only a load or a boundary crossing raises them.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = ZERO_C;
        end else if (load) begin
            if (load_data > MAX_C) begin
                count_d    = MAX_C;
                load_err_d = 1'b1;
            end else begin
                count_d = load_data;
            end
        end else if (en) begin
            if (up_dn) begin
                if (!at_max) begin
                    count_d = count_q + ONE_C;
                end else if (SATURATE == 0) begin
                    count_d = ZERO_C;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - ONE_C;
                end else if (SATURATE == 0) begin
                    count_d = MAX_C;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= ZERO_C;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign tc       = up_dn ? at_max : at_zero;

endmodule

// File: tb/tb_counter_updown_param.sv
// tb/tb_counter_updown_param.sv - scoreboard bench for counter_updown_param (wrap and saturate instances)
module tb_counter_updown_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // sel 0 drives the wrapping instance, sel 1 the saturating one.
    logic [1:0]       reset, clear, load, en, up_dn;
    logic [3:0]       load_data [2];
    logic [3:0]       count [2];
    logic [1:0]       tc, wrap, load_err;

    counter_updown_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset[0]), .clear(clear[0]), .load(load[0]),
        .load_data(load_data[0]), .en(en[0]), .up_dn(up_dn[0]),
        .count(count[0]), .tc(tc[0]), .wrap(wrap[0]), .load_err(load_err[0])
    );

    counter_updown_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset[1]), .clear(clear[1]), .load(load[1]),
        .load_data(load_data[1]), .en(en[1]), .up_dn(up_dn[1]),
        .count(count[1]), .tc(tc[1]), .wrap(wrap[1]), .load_err(load_err[1])
    );

    typedef struct {
        int         sel;
        logic [3:0] cnt;
        logic       wr;
        logic       err;
        logic       t;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            nvec++;
            if (count[e.sel] !== e.cnt || wrap[e.sel] !== e.wr ||
                load_err[e.sel] !== e.err || tc[e.sel] !== e.t) begin
                nerr++;
                $display("FAIL %s: got count=%0d wrap=%b load_err=%b tc=%b, want count=%0d wrap=%b load_err=%b tc=%b",
                         e.name, count[e.sel], wrap[e.sel], load_err[e.sel], tc[e.sel],
                         e.cnt, e.wr, e.err, e.t);
            end
        end
    end

    task automatic step(input int sel, input logic r, input logic c, input logic l,
                        input logic [3:0] d, input logic e, input logic u,
                        input logic [3:0] x_cnt, input logic x_wr, input logic x_err,
                        input logic x_tc, input string name);
        exp_t x;
        @(negedge clk);
        reset = '0; clear = '0; load = '0; en = '0; up_dn = '0;
        load_data[0] = '0; load_data[1] = '0;
        reset[sel] = r; clear[sel] = c; load[sel] = l; en[sel] = e; up_dn[sel] = u;
        load_data[sel] = d;
        x.sel = sel; x.cnt = x_cnt; x.wr = x_wr; x.err = x_err; x.t = x_tc; x.name = name;
        exp_q.push_back(x);
    endtask

    initial begin
        reset = '0; clear = '0; load = '0; en = '0; up_dn = '0;
        load_data[0] = '0; load_data[1] = '0;

        // reset both instances
        step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "s_reset");
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "w_reset0");
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "w_reset1");

        // count up 0..9, wrap to 0, continue to 2
        for (int i = 1; i <= 12; i++) begin
            logic [3:0] c;
            c = 4'(i % 10);
            step(0, 0, 0, 0, 0, 1, 1, c, (i == 10), 0, (c == 4'd9), "w_up");
        end

        // load 3, count down through 0 into 9
        step(0, 0, 0, 1, 3, 0, 0, 3, 0, 0, 0, "w_load3");
        step(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, "w_dn2");
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "w_dn1");
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "w_dn0");
        step(0, 0, 0, 0, 0, 1, 0, 9, 1, 0, 0, "w_dn_wrap9");
        step(0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, "w_dn8");

        // out-of-range load clamps and pulses load_err once
        step(0, 0, 0, 1, 12, 0, 1, 9, 0, 1, 1, "w_load12");
        step(0, 0, 0, 0, 0,  0, 1, 9, 0, 0, 1, "w_err_clears");
        step(0, 0, 0, 1, 7,  0, 1, 7, 0, 0, 0, "w_load7");

        // priority checks at count 5
        step(0, 0, 0, 1, 5, 0, 1, 5, 0, 0, 0, "w_load5a");
        step(0, 0, 1, 1, 2, 1, 1, 0, 0, 0, 0, "w_clr_over_load");
        step(0, 0, 0, 1, 5, 0, 1, 5, 0, 0, 0, "w_load5b");
        step(0, 0, 0, 1, 2, 1, 1, 2, 0, 0, 0, "w_load_over_en");
        step(0, 0, 0, 1, 15, 0, 1, 9, 0, 1, 1, "w_load15");
        step(0, 1, 0, 1, 4, 1, 1, 0, 0, 0, 0, "w_rst_over_load");
        step(0, 0, 0, 1, 9, 0, 1, 9, 0, 0, 1, "w_load9");
        step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, "w_wrap_up");
        step(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, "w_clear_drops_wrap");

        // reset mid-count, resume, then hold with en low
        step(0, 0, 0, 1, 5, 0, 1, 5, 0, 0, 0, "w_load5c");
        step(0, 0, 0, 0, 0, 1, 1, 6, 0, 0, 0, "w_up6");
        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, "w_mid_reset");
        step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, "w_resume1");
        step(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, "w_resume2");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, "w_hold");

        // saturating instance: stick at both ends
        step(1, 0, 0, 1, 8, 0, 1, 8, 0, 0, 0, "s_load8");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 1, "s_sat_hi");
        step(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, "s_load1");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "s_sat_lo");
        step(1, 0, 0, 1, 13, 0, 1, 9, 0, 1, 1, "s_load13");

        begin
            int waited;
            waited = 0;
            while (exp_q.size() != 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (exp_q.size() != 0) begin
                nerr++;
                $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
